// File: rtl/draw_pkg.sv
// Shared types for the draw-engine arbiters.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

endpackage

// File: rtl/draw_circle_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from last+1, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value held (which would infer a latch).
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!valid && req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_circle_arb.sv
// Round-robin scheduler sharing one circle-drawing engine between NREQ
// requesters; latches the winner's parameters and pulses start/ack.
module draw_circle_arb
    import draw_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int NREQ  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CORDW-1:0]    req_x0,
    input  logic [NREQ*CORDW-1:0]    req_y0,
    input  logic [NREQ*CORDW-1:0]    req_r0,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic                     drw_start,
    output logic signed [CORDW-1:0]  drw_x0,
    output logic signed [CORDW-1:0]  drw_y0,
    output logic signed [CORDW-1:0]  drw_r0,
    input  logic                     drw_done
);

    localparam int IW = $clog2(NREQ);

    arb_state_t              state_q, state_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [NREQ-1:0]         ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic                    start_q, start_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           last_q, last_d;
    logic signed [CORDW-1:0] x0_q, x0_d;
    logic signed [CORDW-1:0] y0_q, y0_d;
    logic signed [CORDW-1:0] r0_q, r0_d;

    logic [IW-1:0]           pick_idx;
    logic                    pick_valid;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        busy_d  = busy_q;
        start_d = 1'b0;
        idx_d   = idx_q;
        last_d  = last_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        r0_d    = r0_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    gnt_d   = NREQ'(1) << pick_idx;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    idx_d   = pick_idx;
                    x0_d    = req_x0[pick_idx*CORDW +: CORDW];
                    y0_d    = req_y0[pick_idx*CORDW +: CORDW];
                    r0_d    = req_r0[pick_idx*CORDW +: CORDW];
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Requests and parameters are ignored here; only done ends a draw.
                if (drw_done) begin
                    state_d = IDLE;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            x0_q    <= '0;
            y0_q    <= '0;
            r0_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            r0_q    <= r0_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign drw_start = start_q;
    assign drw_x0    = x0_q;
    assign drw_y0    = y0_q;
    assign drw_r0    = r0_q;

endmodule

// File: tb/tb_draw_circle_arb.sv
// Self-checking bench for draw_circle_arb: expected grants are queued when
// requests are driven and compared when the arbiter issues a draw.
module tb_draw_circle_arb;

    localparam int CORDW = 16;
    localparam int NREQ  = 4;

    typedef struct {
        logic [NREQ-1:0]         g;
        logic signed [CORDW-1:0] x;
        logic signed [CORDW-1:0] y;
        logic signed [CORDW-1:0] r;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*CORDW-1:0]   req_x0, req_y0, req_r0;
    logic [NREQ-1:0]         gnt, ack;
    logic                    busy, drw_start, drw_done;
    logic signed [CORDW-1:0] drw_x0, drw_y0, drw_r0;

    exp_t sb_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    draw_circle_arb #(
        .CORDW (CORDW),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_r0    (req_r0),
        .gnt       (gnt),
        .ack       (ack),
        .busy      (busy),
        .drw_start (drw_start),
        .drw_x0    (drw_x0),
        .drw_y0    (drw_y0),
        .drw_r0    (drw_r0),
        .drw_done  (drw_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_params(input int i, input logic signed [CORDW-1:0] x,
                              input logic signed [CORDW-1:0] y, input logic signed [CORDW-1:0] r);
        req_x0[i*CORDW +: CORDW] = x;
        req_y0[i*CORDW +: CORDW] = y;
        req_r0[i*CORDW +: CORDW] = r;
    endtask

    task automatic push_exp(input int i, input logic signed [CORDW-1:0] x,
                            input logic signed [CORDW-1:0] y, input logic signed [CORDW-1:0] r);
        exp_t e;
        e.g = NREQ'(1) << i;
        e.x = x;
        e.y = y;
        e.r = r;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   gnt, 0);
        check({tag, "_ack"},   ack, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_start"}, drw_start, 0);
        check({tag, "_x0"},    drw_x0, 0);
        check({tag, "_y0"},    drw_y0, 0);
        check({tag, "_r0"},    drw_r0, 0);
    endtask

    // Waits (bounded) for a start pulse, then compares it against the next expected grant.
    task automatic wait_start();
        int n = 0;
        while (drw_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("start_seen", drw_start, 1);
        check("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) cur = sb_q.pop_front();
        check("gnt",    gnt, cur.g);
        check("busy",   busy, 1);
        check("ack_iss", ack, 0);
        check("drw_x0", drw_x0, cur.x);
        check("drw_y0", drw_y0, cur.y);
        check("drw_r0", drw_r0, cur.r);
    endtask

    task automatic leave_issue();
        tick();
        check("start_fall", drw_start, 0);
        check("busy_wait",  busy, 1);
        check("gnt_wait",   gnt, cur.g);
    endtask

    task automatic finish_draw(input int len, input bit drop);
        repeat (len) begin
            tick();
            check("r0_hold",  drw_r0, cur.r);
            check("ack_wait", ack, 0);
        end
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        check("ack",       ack, cur.g);
        check("gnt_clear", gnt, 0);
        check("busy_clear", busy, 0);
        if (drop) req = req & ~cur.g;
        tick();
        check("ack_fall", ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_x0   = '0;
        req_y0   = '0;
        req_r0   = '0;
        drw_done = 1'b0;
        cur      = '{g: '0, x: '0, y: '0, r: '0};
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Single requester
        set_params(2, 100, 80, 10);
        push_exp(2, 100, 80, 10);
        req = 4'b0100;
        wait_start();
        leave_issue();
        finish_draw(4, 1'b1);
        tick();
        check("single_idle_gnt", gnt, 0);
        check("single_idle_start", drw_start, 0);

        // Rotation after reset with all requesters held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_params(i, 16'(i * 10), 16'(i * 20), 16'(i + 1));
        for (int i = 0; i < NREQ; i++) push_exp(i, 16'(i * 10), 16'(i * 20), 16'(i + 1));
        push_exp(0, 0, 0, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start();
            if (k == 4) req = '0;
            leave_issue();
            finish_draw(3, 1'b0);
        end
        check("rot_idle_gnt", gnt, 0);

        // Latched parameters, request dropped during WAIT
        set_params(1, 7, 9, 5);
        push_exp(1, 7, 9, 5);
        req = 4'b0010;
        wait_start();
        leave_issue();
        req_r0[1*CORDW +: CORDW] = 16'd50;
        req = '0;
        finish_draw(3, 1'b0);

        // Spurious done in IDLE, then in ISSUE
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        check("spur_idle_ack",   ack, 0);
        check("spur_idle_busy",  busy, 0);
        check("spur_idle_gnt",   gnt, 0);
        check("spur_idle_start", drw_start, 0);
        set_params(0, 11, 22, 33);
        push_exp(0, 11, 22, 33);
        req = 4'b0001;
        wait_start();
        drw_done = 1'b1;
        tick();
        drw_done = 1'b0;
        check("spur_iss_ack",  ack, 0);
        check("spur_iss_busy", busy, 1);
        check("spur_iss_gnt",  gnt, 4'b0001);
        finish_draw(2, 1'b1);

        // Reset mid-draw for requester 3 (negative radius forwarded)
        set_params(3, -5, 6, -7);
        push_exp(3, -5, 6, -7);
        req = 4'b1000;
        wait_start();
        leave_issue();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        set_params(1, 1, 2, 3);
        push_exp(1, 1, 2, 3);
        req = 4'b1010;
        rst = 1'b0;
        wait_start();
        req = 4'b0010;
        leave_issue();
        finish_draw(2, 1'b1);

        // Full-width coordinates
        set_params(0, -32768, 32767, 1);
        push_exp(0, -32768, 32767, 1);
        req = 4'b0001;
        wait_start();
        leave_issue();
        finish_draw(1, 1'b1);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/draw_circle_arb.md
# draw_circle_arb

Round-robin scheduler that shares one circle-drawing engine between `NREQ` independent requesters. Each requester presents a centre and radius and holds a request. The block grants one requester at a time, forwards its parameters to the engine with a single-cycle start, and returns a one-cycle acknowledge when the engine reports done. It sits between graphics command sources (sprite/UI generators) and the circle drawer in the framebuffer write path.

## Interface
- `CORDW`, 16, signed coordinate width (matches the engine)
- `NREQ`, 4, number of requesters (2..8)
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `req`  in  NREQ  per-requester draw request, level; held until the matching `ack`
- `req_x0`, `req_y0`  in  NREQ×CORDW signed  per-requester centre, packed (requester i at [i*CORDW +: CORDW])
- `req_r0`  in  NREQ×CORDW signed  per-requester radius, packed
- `gnt`  out  NREQ  one-hot grant, high from issue through completion
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester
- `busy`  out  1  a granted draw is in progress
- `drw_start`  out  1  engine start, one-cycle pulse
- `drw_x0`, `drw_y0`, `drw_r0`  out  CORDW signed  latched parameters to the engine, stable while `busy`
- `drw_done`  in  1  engine completion pulse

## Operation
- States:
  - IDLE: no grant is active.
  - ISSUE: lasts exactly one cycle; `drw_start`=1.
  - WAIT: waiting for `drw_done`.
- IDLE → ISSUE when `|req`:
  - Choose the winner by round-robin, searching upward from `last+1` modulo NREQ.
  - Latch the winner's x0/y0/r0 into `drw_*`.
  - Set `gnt` to the winner's one-hot bit and set `busy`=1.
  - Set `drw_start` high for the ISSUE cycle only.
- ISSUE → WAIT unconditionally.
- WAIT → IDLE on `drw_done`:
  - Pulse `ack[idx]`=1 for one cycle.
  - Clear `gnt` and `busy`.
  - Set `last`=idx.
- `req` deasserted during ISSUE/WAIT: ignored. The draw runs to completion and `ack` is still pulsed.
- `req_*` changes after the grant: ignored, because the parameters are latched.
- `drw_done` in IDLE or ISSUE: ignored, no `ack`.
- Radius is forwarded unchanged, including 0 and negative values. Engine behaviour for these is the engine's concern.
- Reset (async, any state):
  - Return to IDLE.
  - `gnt`, `ack`, `busy`, `drw_start` = 0.
  - `drw_x0`/`drw_y0`/`drw_r0` = 0.
  - `last` = NREQ-1, so requester 0 has first priority after reset.
  - The top level resets the engine on the same `rst`.

## Timing
- All outputs are registered.
- Request → start latency:
  - `req` seen at edge k (IDLE) → `gnt`, `busy`, `drw_start`, `drw_*` valid after edge k.
  - `drw_start` falls after edge k+1.
- Completion:
  - `drw_done` sampled at edge m → `ack` high after edge m, low after edge m+1.
  - `gnt`/`busy` low after edge m.
- A requester still holding `req` in the `ack` cycle is treated as a new request. The next grant is issued no earlier than edge m+1, and round-robin applies.
- Back-to-back throughput: one draw per engine duration plus 2 cycles of overhead.
- At most one `gnt` bit and at most one `ack` bit are high in any cycle.

## Structure
- `draw_pkg`: state enum `arb_state_t {IDLE, ISSUE, WAIT}`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[NREQ]`, `last` index.
  - Outputs: winner index, `valid`.
  - Reused by later line/rect arbiters.
- Index width is `$clog2(NREQ)`.

## Test plan
- **Single requester:** `req[2]`=1 with (x0,y0,r0)=(100,80,10).
  - Grant: `gnt`=4'b0100, `drw_start` pulses once, `drw_x0/y0/r0`=100/80/10.
  - Completion: `drw_done` pulses → `ack`=4'b0100 for 1 cycle, `busy` returns to 0.
- **Rotation:** all four requesters held continuously after reset.
  - Grant order 0,1,2,3,0.
  - Every `ack` matches the previous `gnt`, with no overlap.
- **Latched parameters:** requester 1 changes `req_r0` from 5 to 50 and drops `req` during WAIT.
  - `drw_r0` stays 5, and `ack[1]` still pulses.
- **Spurious done:** `drw_done` pulsed in IDLE, then in the ISSUE cycle.
  - `ack` stays 0 and the state is unchanged.
- **Reset mid-draw:** assert `rst` in WAIT for requester 3.
  - All outputs are 0 immediately (asynchronously).
  - After release with `req`=4'b1010, requester 1 is granted first.
- **Full-width coordinates:** x0=-32768, y0=32767, r0=1.
  - Values are forwarded bit-exact on `drw_*`.
